// File: rtl/finite_pkg.sv
// Shared widths, FSM state and BCD result type for the modulo-100 counter datapath.
package finite_pkg;

  localparam int unsigned FINITE_W   = 7;
  localparam int unsigned FINITE_MOD = 100;
  localparam int unsigned BCD_W      = 8;

  // Result shown for out-of-range inputs (the hundreds digit cannot be represented).
  localparam logic [BCD_W-1:0] BCD_ERR = 8'h99;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_t;

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more.
module bcd_adj3 (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  always_comb begin
    nib_o = nib_i;
    if (nib_i >= 4'd5) begin
      nib_o = nib_i + 4'd3;
    end
  end

endmodule

// File: rtl/finite_bcd.sv
// Sequential binary-to-BCD converter: one 7-bit value per transaction, IN_W shift steps,
// registered result held in DONE until the downstream handshake.
module finite_bcd
  import finite_pkg::*;
#(
  parameter int unsigned IN_W    = FINITE_W,
  parameter int unsigned MODULUS = FINITE_MOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BCD_W-1:0] out_bcd,
  output logic             out_err
);

  localparam int unsigned     CatW     = BCD_W + IN_W;
  localparam logic [2:0]      LastStep = 3'(IN_W - 1);
  localparam logic [IN_W-1:0] ModLim   = IN_W'(MODULUS);

  state_e state_q, state_d;

  logic [IN_W-1:0] shreg_q, shreg_d;
  bcd_t            scratch_q, scratch_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            err_q, err_d;
  bcd_t            out_bcd_q, out_bcd_d;
  logic            out_err_q, out_err_d;

  logic [3:0]      tens_adj, units_adj;
  logic [CatW-1:0] cat, cat_shift;

  bcd_adj3 u_adj_tens (
    .nib_i (scratch_q.tens),
    .nib_o (tens_adj)
  );

  bcd_adj3 u_adj_units (
    .nib_i (scratch_q.units),
    .nib_o (units_adj)
  );

  // Corrected scratch and binary operand shift as one register pair.
  assign cat       = {tens_adj, units_adj, shreg_q};
  assign cat_shift = {cat[CatW-2:0], 1'b0};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StShift;
      StShift: if (cnt_q == LastStep) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    out_bcd_d = out_bcd_q;
    out_err_d = out_err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          shreg_d   = in_data;
          scratch_d = '0;
          cnt_d     = '0;
          err_d     = (in_data >= ModLim);
        end
      end
      StShift: begin
        {scratch_d, shreg_d} = cat_shift;
        cnt_d                = cnt_q + 3'd1;
        if (cnt_q == LastStep) begin
          out_bcd_d = err_q ? bcd_t'(BCD_ERR) : bcd_t'(cat_shift[CatW-1:IN_W]);
          out_err_d = err_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      out_bcd_q <= '0;
      out_err_q <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      out_bcd_q <= out_bcd_d;
      out_err_q <= out_err_d;
    end
  end

  // Outputs; in_ready is held low while reset is asserted.
  always_comb begin
    in_ready  = rst && (state_q == StIdle);
    out_valid = (state_q == StDone);
    out_bcd   = out_bcd_q;
    out_err   = out_err_q;
  end

endmodule

// File: tb/tb_finite_bcd.sv
// Randomized and directed bench for finite_bcd against a decimal-arithmetic reference model.
module tb_finite_bcd;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_bcd;
  logic       out_err;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int n_out = 0;
  int last_acc = 0;
  bit have_last = 0;
  bit stream_mode = 0;
  int exp_q[$];

  finite_bcd dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_bcd(input int v);
    if (v >= 100) return 8'h99;
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic logic model_err(input int v);
    return v >= 100;
  endfunction

  // Scoreboard: handshakes are decided by values stable at the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_spurious", out_valid, 1'b0);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("sb_bcd", out_bcd, model_bcd(e));
          check("sb_err", out_err, model_err(e));
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(int'(in_data));
        if (stream_mode && have_last) check("accept_gap", cyc - last_acc, 9);
        last_acc  = cyc;
        have_last = 1;
      end
    end
  end

  task automatic send(input int v);
    bit ok = 0;
    in_data  = 7'(v);
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (in_ready) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) check("send_wait", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  task automatic recv(input int v, input int hold);
    bit ok = 0;
    logic [7:0] first_bcd;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      check("recv_wait", out_valid, 1'b1);
      return;
    end
    check("latency", cyc - acc_cyc, 7);
    check("out_bcd", out_bcd, model_bcd(v));
    check("out_err", out_err, model_err(v));
    first_bcd = out_bcd;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1'b1);
      check("hold_bcd", out_bcd, first_bcd);
      check("hold_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_valid", out_valid, 1'b0);
    check("post_ready", in_ready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int nv;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_bcd", out_bcd, 8'h00);
    check("rst_out_err", out_err, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready", in_ready, 1'b1);

    send(0);   recv(0, 0);
    send(99);  recv(99, 0);
    send(57);  recv(57, 0);
    send(100); recv(100, 0);
    send(127); recv(127, 0);

    // Stall in DONE while upstream already offers the next value.
    send(64);
    in_data  = 7'd5;
    in_valid = 1'b1;
    recv(64, 5);
    send(5);
    recv(5, 0);

    // Abort at shift step 3.
    send(42);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    nv = 0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) nv++;
      @(posedge clk); #1;
    end
    check("abort_no_valid", nv, 0);
    send(13); recv(13, 0);

    // Back-to-back stream with downstream always ready.
    base        = n_out;
    have_last   = 0;
    stream_mode = 1;
    out_ready   = 1'b1;
    for (int v = 0; v < 100; v++) begin
      bit ok = 0;
      in_data  = 7'(v);
      in_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
        if (in_ready) begin
          ok = 1;
          break;
        end
        @(posedge clk); #1;
      end
      if (!ok) check("stream_wait", in_ready, 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("stream_count", n_out - base, 100);
    check("stream_drain", exp_q.size(), 0);
    stream_mode = 0;
    out_ready   = 1'b0;

    for (int i = 0; i < 40; i++) begin
      int v;
      v = int'($urandom_range(0, 127));
      send(v);
      recv(v, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
